// File: rtl/arc4_pkg.sv
// Shared ARC4 encrypt definitions: key/memory geometry, FSM state codes, key byte selection.
package arc4_pkg;

  localparam int KEY_W     = 24;
  localparam int MEM_DEPTH = 256;

  typedef logic [4:0] state_t;

  localparam state_t IDLE    = 5'd0;
  localparam state_t INIT    = 5'd1;
  localparam state_t KSA_RDI = 5'd2;
  localparam state_t KSA_WTI = 5'd3;
  localparam state_t KSA_RDJ = 5'd4;
  localparam state_t KSA_WTJ = 5'd5;
  localparam state_t KSA_WRI = 5'd6;
  localparam state_t KSA_WRJ = 5'd7;
  localparam state_t W_SCHED = 5'd8;
  localparam state_t P_LEN   = 5'd9;
  localparam state_t P_RDI   = 5'd10;
  localparam state_t P_WTI   = 5'd11;
  localparam state_t P_RDJ   = 5'd12;
  localparam state_t P_WTJ   = 5'd13;
  localparam state_t P_WRI   = 5'd14;
  localparam state_t P_WRJ   = 5'd15;
  localparam state_t P_RDP   = 5'd16;
  localparam state_t P_WTP   = 5'd17;
  localparam state_t P_WRC   = 5'd18;
  localparam state_t DONE    = 5'd19;

  // Key bytes are big-endian: byte 0 is the most significant.
  function automatic logic [7:0] key_byte(input logic [KEY_W-1:0] key, input logic [7:0] idx);
    logic [1:0] n;
    n = 2'(idx % 8'd3);
    case (n)
      2'd0:    key_byte = key[KEY_W-1 -: 8];
      2'd1:    key_byte = key[KEY_W-9 -: 8];
      default: key_byte = key[KEY_W-17 -: 8];
    endcase
  endfunction

endpackage

// File: rtl/arc4_encrypt_if.sv
// Host handshake plus S/pt/ct RAM ports of arc4_encrypt.
// cycles only exists when ARC4_ENC_CYCLE_CNT_EN is defined.
interface arc4_encrypt_if;
  import arc4_pkg::*;

  logic             en;
  logic             rdy;
  logic [KEY_W-1:0] key;
  logic [7:0]       s_addr;
  logic [7:0]       s_rddata;
  logic [7:0]       s_wrdata;
  logic             s_wren;
  logic [7:0]       pt_addr;
  logic [7:0]       pt_rddata;
  logic [7:0]       ct_addr;
  logic [7:0]       ct_wrdata;
  logic             ct_wren;
`ifdef ARC4_ENC_CYCLE_CNT_EN
  logic [31:0]      cycles;

  modport master (input en, key, s_rddata, pt_rddata,
                  output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren, cycles);
  modport slave  (output en, key, s_rddata, pt_rddata,
                  input rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren, cycles);
`else
  modport master (input en, key, s_rddata, pt_rddata,
                  output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren);
  modport slave  (output en, key, s_rddata, pt_rddata,
                  input rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren);
`endif

endinterface

// File: rtl/arc4_sbox_sched.sv
// S-box init (S[i]=i) followed by the key-scheduling swaps, with its own en/rdy handshake.
module arc4_sbox_sched
  import arc4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [KEY_W-1:0] key,
  input  logic [7:0]       s_rddata,
  output logic             rdy,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_wrdata,
  output logic             s_wren
);

  localparam logic [7:0] LAST = 8'(MEM_DEPTH - 1);

  state_t           state_q, state_d;
  logic [7:0]       i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [KEY_W-1:0] key_q, key_d;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    sj_d     = sj_q;
    key_d    = key_q;
    rdy      = (state_q == IDLE);
    s_addr   = i_q;
    s_wrdata = 8'd0;
    s_wren   = 1'b0;
    case (state_q)
      IDLE: if (en) begin
        key_d   = key;
        i_d     = 8'd0;
        j_d     = 8'd0;
        state_d = INIT;
      end
      INIT: begin
        s_wrdata = i_q;
        s_wren   = 1'b1;
        i_d      = i_q + 8'd1;
        if (i_q == LAST) state_d = KSA_RDI;
      end
      KSA_RDI: state_d = KSA_WTI;
      KSA_WTI: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata + key_byte(key_q, i_q);
        state_d = KSA_RDJ;
      end
      KSA_RDJ: begin
        s_addr  = j_q;
        state_d = KSA_WTJ;
      end
      KSA_WTJ: begin
        s_addr  = j_q;
        sj_d    = s_rddata;
        state_d = KSA_WRI;
      end
      KSA_WRI: begin
        s_wrdata = sj_q;
        s_wren   = 1'b1;
        state_d  = KSA_WRJ;
      end
      // When i==j both writes carry the same value, so the swap is still correct.
      KSA_WRJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        i_d      = i_q + 8'd1;
        state_d  = (i_q == LAST) ? IDLE : KSA_RDI;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
    end
  end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: runs arc4_sbox_sched, then PRGA writing length-prefixed ciphertext.
// Optional ARC4_ENC_CYCLE_CNT_EN adds a saturating busy-cycle counter on bus.cycles.
module arc4_encrypt
  import arc4_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  arc4_encrypt_if.master bus
);

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
  logic [7:0] si_q, si_d, sj_q, sj_d, pad_q, pad_d, ptb_q, ptb_d;

  logic       sched_en, sched_rdy, sched_s_wren;
  logic [7:0] sched_s_addr, sched_s_wrdata;
  logic [7:0] s_addr, s_wrdata, ct_wrdata;
  logic       s_wren, ct_wren;

  arc4_sbox_sched u_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sched_en),
    .key      (bus.key),
    .s_rddata (bus.s_rddata),
    .rdy      (sched_rdy),
    .s_addr   (sched_s_addr),
    .s_wrdata (sched_s_wrdata),
    .s_wren   (sched_s_wren)
  );

  // pt_addr sits at k=0 while the scheduler runs, so pt[0] is ready the moment it finishes.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    pad_d     = pad_q;
    ptb_d     = ptb_q;
    sched_en  = 1'b0;
    s_addr    = sched_s_addr;
    s_wrdata  = sched_s_wrdata;
    s_wren    = sched_s_wren;
    ct_wrdata = pad_q ^ ptb_q;
    ct_wren   = 1'b0;
    case (state_q)
      IDLE: if (bus.en) begin
        sched_en = 1'b1;
        i_d      = 8'd0;
        j_d      = 8'd0;
        k_d      = 8'd0;
        len_d    = 8'd0;
        state_d  = W_SCHED;
      end
      W_SCHED: if (sched_rdy) begin
        len_d   = bus.pt_rddata;
        state_d = P_LEN;
      end
      P_LEN: begin
        ct_wrdata = len_q;
        ct_wren   = 1'b1;
        if (len_q == 8'd0) begin
          state_d = DONE;
        end else begin
          i_d     = 8'd1;
          k_d     = 8'd1;
          state_d = P_RDI;
        end
      end
      P_RDI: begin
        s_addr  = i_q;
        state_d = P_WTI;
      end
      P_WTI: begin
        si_d    = bus.s_rddata;
        j_d     = j_q + bus.s_rddata;
        state_d = P_RDJ;
      end
      P_RDJ: begin
        s_addr  = j_q;
        state_d = P_WTJ;
      end
      P_WTJ: begin
        sj_d    = bus.s_rddata;
        state_d = P_WRI;
      end
      P_WRI: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
        state_d  = P_WRJ;
      end
      P_WRJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = P_RDP;
      end
      P_RDP: begin
        s_addr  = si_q + sj_q;
        state_d = P_WTP;
      end
      P_WTP: begin
        pad_d   = bus.s_rddata;
        ptb_d   = bus.pt_rddata;
        state_d = P_WRC;
      end
      P_WRC: begin
        ct_wren = 1'b1;
        if (k_q == len_q) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          i_d     = i_q + 8'd1;
          state_d = P_RDI;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 8'd0;
      len_q   <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      pad_q   <= 8'd0;
      ptb_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      pad_q   <= pad_d;
      ptb_q   <= ptb_d;
    end
  end

  assign bus.rdy       = (state_q == IDLE);
  assign bus.s_addr    = s_addr;
  assign bus.s_wrdata  = s_wrdata;
  assign bus.s_wren    = s_wren;
  assign bus.pt_addr   = k_q;
  assign bus.ct_addr   = k_q;
  assign bus.ct_wrdata = ct_wrdata;
  assign bus.ct_wren   = ct_wren;

`ifdef ARC4_ENC_CYCLE_CNT_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (state_q == IDLE) begin
      if (bus.en) cycles_d = 32'd0;
    end else if (cycles_q != 32'hFFFF_FFFF) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycles_q <= 32'd0;
    else        cycles_q <= cycles_d;
  end

  assign bus.cycles = cycles_q;
`endif

endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt: RAM models plus a plain-array RC4 reference model.
module tb_arc4_encrypt;
  import arc4_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  arc4_encrypt_if bus();

  arc4_encrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] exp_ct [256];
  logic [7:0] ks     [256];

  int compared   = 0;
  int mismatched = 0;
  int ct_wr_count   = 0;
  int overlap_count = 0;
  logic [7:0] ct_last_addr = 8'd0;

  // Single-port synchronous RAMs with registered read data, plus write bookkeeping.
  always @(posedge clk) begin
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.pt_rddata <= pt_mem[bus.pt_addr];
    if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
    if (bus.ct_wren) begin
      ct_mem[bus.ct_addr] <= bus.ct_wrdata;
      ct_last_addr        <= bus.ct_addr;
      ct_wr_count          = ct_wr_count + 1;
    end
    if (bus.s_wren && bus.ct_wren) overlap_count = overlap_count + 1;
  end

  // Textbook RC4: S[i]=i, key schedule with key[i mod 3], then keystream bytes ks[1..len].
  function automatic void make_keystream(input logic [23:0] key, input int len);
    int s[256];
    int i, j, t;
    logic [7:0] kb[3];
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + int'(kb[n % 3])) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks[k] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endfunction

  function automatic void make_expected(input logic [23:0] key, input int len);
    make_keystream(key, len);
    exp_ct[0] = 8'(len);
    for (int k = 1; k <= len; k++) exp_ct[k] = pt_mem[k] ^ ks[k];
  endfunction

  // Index of the first ct byte differing from exp_ct, or -1.
  function automatic int ct_first_bad(input int len);
    for (int k = 0; k <= len; k++)
      if (ct_mem[k] !== exp_ct[k]) return k;
    return -1;
  endfunction

  task automatic load_random_pt(input int len);
    pt_mem[0] = 8'(len);
    for (int k = 1; k < 256; k++) pt_mem[k] = 8'($urandom);
    for (int k = 0; k < 256; k++) begin
      ct_mem[k] = 8'($urandom);
      s_mem[k]  = 8'($urandom);
    end
  endtask

  task automatic start_run(input logic [23:0] key);
    @(negedge clk);
    ct_wr_count   = 0;
    overlap_count = 0;
    bus.key = key;
    bus.en  = 1'b1;
    @(negedge clk);
    bus.en  = 1'b0;
  endtask

  // Counts cycles with rdy low, starting at the first negedge after acceptance.
  task automatic wait_done(output int n_low, output bit timed_out);
    n_low     = 0;
    timed_out = 1'b0;
    while (bus.rdy !== 1'b1 && !timed_out) begin
      n_low++;
      @(negedge clk);
      if (n_low > 5000) timed_out = 1'b1;
    end
  endtask

  task automatic test_reset;
    bus.en  = 1'b0;
    bus.key = '0;
    #12;
    compared++;
    if (bus.rdy !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reset_rdy: got %b, expected 1", bus.rdy);
    end
    compared++;
    if (bus.s_wren !== 1'b0 || bus.ct_wren !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_wren: got s=%b ct=%b, expected 0 0", bus.s_wren, bus.ct_wren);
    end
    compared++;
    if (bus.s_addr !== 8'd0 || bus.pt_addr !== 8'd0 || bus.ct_addr !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_addr: got s=%h pt=%h ct=%h, expected 00 00 00", bus.s_addr, bus.pt_addr, bus.ct_addr);
    end
    compared++;
    if (bus.s_wrdata !== 8'd0 || bus.ct_wrdata !== 8'd0) begin
      mismatched++; $display("[TB] FAIL reset_wrdata: got s=%h ct=%h, expected 00 00", bus.s_wrdata, bus.ct_wrdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_known_vector;
    logic [7:0] msg [10];
    logic [7:0] kv  [10];
    int n_low, bad;
    bit to;
    msg = '{8'h09, "P", "l", "a", "i", "n", "t", "e", "x", "t"};
    kv  = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    load_random_pt(9);
    for (int k = 0; k < 10; k++) pt_mem[k] = msg[k];
    start_run(24'h4B6579);
    wait_done(n_low, to);
    compared++;
    if (to) begin
      mismatched++; $display("[TB] FAIL kv_timeout: rdy low after %0d cycles, expected high", n_low);
    end
    bad = -1;
    for (int k = 0; k < 10; k++) if (bad < 0 && ct_mem[k] !== kv[k]) bad = k;
    compared++;
    if (bad >= 0) begin
      mismatched++; $display("[TB] FAIL kv_ct: ct[%0d]=%h, expected %h", bad, ct_mem[bad], kv[bad]);
    end
    @(negedge clk);
    compared++;
    if (bus.rdy !== 1'b1) begin
      mismatched++; $display("[TB] FAIL kv_rdy_after: got %b, expected 1", bus.rdy);
    end
    compared++;
    if (ct_wr_count !== 10) begin
      mismatched++; $display("[TB] FAIL kv_wr_count: got %0d, expected 10", ct_wr_count);
    end
  endtask

  task automatic test_round_trip;
    int n_low, bad;
    bit to;
    load_random_pt(53);
    start_run(24'h000018);
    wait_done(n_low, to);
    compared++;
    if (to || n_low + 1 > 1796 + 10 * 53) begin
      mismatched++; $display("[TB] FAIL rt_latency: got %0d cycles, expected <= %0d", n_low + 1, 1796 + 530);
    end
    make_keystream(24'h000018, 53);
    bad = -1;
    if (ct_mem[0] !== pt_mem[0]) bad = 0;
    for (int k = 1; k <= 53; k++) if (bad < 0 && (ct_mem[k] ^ ks[k]) !== pt_mem[k]) bad = k;
    compared++;
    if (bad >= 0) begin
      mismatched++;
      $display("[TB] FAIL rt_recovered: byte %0d got %h, expected %h", bad,
               (bad == 0) ? ct_mem[0] : (ct_mem[bad] ^ ks[bad]), pt_mem[bad]);
    end
  endtask

  task automatic test_len_zero;
    int n_low;
    bit to;
    load_random_pt(0);
    start_run(24'h123456);
    wait_done(n_low, to);
    compared++;
    if (to || n_low + 1 > 1800) begin
      mismatched++; $display("[TB] FAIL len0_latency: got %0d cycles, expected <= 1800", n_low + 1);
    end
    compared++;
    if (ct_mem[0] !== 8'h00) begin
      mismatched++; $display("[TB] FAIL len0_ct0: got %h, expected 00", ct_mem[0]);
    end
    compared++;
    if (ct_wr_count !== 1) begin
      mismatched++; $display("[TB] FAIL len0_wr_count: got %0d, expected 1", ct_wr_count);
    end
  endtask

  task automatic test_en_during_ksa;
    logic [23:0] key_a;
    int n_low, bad;
    bit to;
    key_a = 24'($urandom);
    load_random_pt(20);
    start_run(key_a);
    repeat (600) @(negedge clk);
    bus.key = key_a ^ 24'h5A0103;
    bus.en  = 1'b1;
    @(negedge clk);
    bus.en  = 1'b0;
    wait_done(n_low, to);
    make_expected(key_a, 20);
    bad = ct_first_bad(20);
    compared++;
    if (to || bad >= 0) begin
      mismatched++;
      $display("[TB] FAIL ignore_en_ct: timeout=%0d first bad byte %0d got %h, expected %h",
               to, bad, ct_mem[(bad < 0) ? 0 : bad], exp_ct[(bad < 0) ? 0 : bad]);
    end
    compared++;
    if (ct_wr_count !== 21) begin
      mismatched++; $display("[TB] FAIL ignore_en_wr_count: got %0d, expected 21", ct_wr_count);
    end
  endtask

  task automatic test_reset_mid_prga;
    logic [23:0] key;
    int n_low, bad, guard, held;
    bit to;
    key = 24'($urandom);
    load_random_pt(40);
    start_run(key);
    guard = 0;
    while (ct_wr_count < 1 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    compared++;
    if (ct_wr_count < 1) begin
      mismatched++; $display("[TB] FAIL mid_reach_prga: ct writes %0d, expected >= 1", ct_wr_count);
    end
    repeat (60) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (bus.rdy !== 1'b1 || bus.s_wren !== 1'b0 || bus.ct_wren !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_async_reset: got rdy=%b s_wren=%b ct_wren=%b, expected 1 0 0",
               bus.rdy, bus.s_wren, bus.ct_wren);
    end
    held = ct_wr_count;
    repeat (20) @(negedge clk);
    compared++;
    if (ct_wr_count !== held) begin
      mismatched++; $display("[TB] FAIL mid_no_writes: got %0d writes, expected %0d", ct_wr_count, held);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 256; k++) ct_mem[k] = 8'($urandom);
    start_run(key);
    wait_done(n_low, to);
    make_expected(key, 40);
    bad = ct_first_bad(40);
    compared++;
    if (to || bad >= 0) begin
      mismatched++;
      $display("[TB] FAIL mid_restart_ct: timeout=%0d first bad byte %0d got %h, expected %h",
               to, bad, ct_mem[(bad < 0) ? 0 : bad], exp_ct[(bad < 0) ? 0 : bad]);
    end
  endtask

  task automatic test_random_lengths;
    int lens[4];
    int n_low, bad, len;
    bit to;
    logic [23:0] key;
    lens = '{1, 2, 255, int'($urandom_range(3, 254))};
    foreach (lens[t]) begin
      len = lens[t];
      key = 24'($urandom);
      load_random_pt(len);
      start_run(key);
      wait_done(n_low, to);
      make_expected(key, len);
      bad = ct_first_bad(len);
      compared++;
      if (to || bad >= 0) begin
        mismatched++;
        $display("[TB] FAIL rand_ct len=%0d: timeout=%0d first bad byte %0d got %h, expected %h",
                 len, to, bad, ct_mem[(bad < 0) ? 0 : bad], exp_ct[(bad < 0) ? 0 : bad]);
      end
      compared++;
      if (ct_wr_count !== len + 1 || ct_last_addr !== 8'(len)) begin
        mismatched++;
        $display("[TB] FAIL rand_writes len=%0d: got %0d writes last addr %0d, expected %0d writes last addr %0d",
                 len, ct_wr_count, ct_last_addr, len + 1, len);
      end
      compared++;
      if (n_low + 1 > 1796 + 10 * len) begin
        mismatched++;
        $display("[TB] FAIL rand_latency len=%0d: got %0d cycles, expected <= %0d", len, n_low + 1, 1796 + 10 * len);
      end
      compared++;
      if (overlap_count !== 0) begin
        mismatched++; $display("[TB] FAIL rand_wren_overlap len=%0d: got %0d, expected 0", len, overlap_count);
      end
    end
  endtask

`ifdef ARC4_ENC_CYCLE_CNT_EN
  task automatic test_cycle_count;
    int n_low;
    bit to;
    logic [31:0] snap;
    load_random_pt(9);
    start_run(24'($urandom));
    wait_done(n_low, to);
    snap = bus.cycles;
    compared++;
    if (to || snap !== 32'(n_low)) begin
      mismatched++; $display("[TB] FAIL cycles_value: got %0d, expected %0d", snap, n_low);
    end
    repeat (5) @(negedge clk);
    compared++;
    if (bus.cycles !== 32'(n_low)) begin
      mismatched++; $display("[TB] FAIL cycles_hold: got %0d, expected %0d", bus.cycles, n_low);
    end
  endtask
`endif

  initial begin
    bus.en  = 1'b0;
    bus.key = '0;
    test_reset;
    test_known_vector;
    test_round_trip;
    test_len_zero;
    test_en_during_ksa;
    test_reset_mid_prga;
    test_random_lengths;
`ifdef ARC4_ENC_CYCLE_CNT_EN
    test_cycle_count;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
